snn_ctrl: RTL
=============

// Module: snn_ctrl
// PURPOSE
//  Top-level control FSM for the SNN digit classifier. Collects a 28x28 binary image
//  from UART_RX as 98 bytes and unpacks it bit-serially into the 784x1 input RAM.
//  Then pulses snn_core start, waits for done, latches the digit and returns it as an
//  ASCII character via UART_TX. Sits between uart_rx/uart_tx, ram_input_unit and snn_core.
// PARAMETERS
//  NUM_BYTES      98     image bytes per frame (8 pixels/byte)
//  ADDR_W         10     input RAM address width (784 locations used)
//  TIMEOUT_CYCLES 2**20  core_done watchdog limit (only with SNN_CTRL_TIMEOUT_EN)
// PORTS
//  clk         in   1       system clock, 50 MHz
//  rst_n       in   1       reset, asynchronous, active-low
//  rx_rdy      in   1       1-cycle pulse from uart_rx: rx_data valid
//  rx_data     in   8       received byte
//  ram_we      out  1       input RAM write enable
//  ram_addr    out  ADDR_W  input RAM address
//  ram_data    out  1       input RAM write data (one pixel)
//  core_start  out  1       1-cycle start pulse to snn_core
//  core_done   in   1       1-cycle done pulse from snn_core
//  core_digit  in   4       classification result, valid with core_done
//  tx_rdy      in   1       uart_tx idle/ready
//  tx_start    out  1       1-cycle transmit pulse to uart_tx
//  tx_data     out  8       byte to transmit
//  digit       out  4       last classified digit, drives LEDs
//  busy        out  1       high in every state except IDLE
//  overrun     out  1       sticky: a received byte was dropped
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; byte_cnt=0; bit_cnt=0; hold buffer empty.
//  States: IDLE, LOAD, UNPACK, START, WAIT, TX.
//  IDLE:   rx_rdy -> capture rx_data into shift reg, byte_cnt=0 -> UNPACK.
//  LOAD:   wait for rx_rdy (or pending hold buffer) -> capture byte -> UNPACK.
//  UNPACK: 8 cycles, one pixel per cycle, LSB first:
//          ram_we=1, ram_data=shift[0], ram_addr=byte_cnt*8+bit_cnt.
//          After bit 7, byte_cnt++. Go to START if byte_cnt==NUM_BYTES, else LOAD.
//          Addresses 0..783 written exactly once per frame; ram_we=0 outside UNPACK.
//  Hold buffer: 1 entry. An rx_rdy during UNPACK stores the byte and sets pending.
//          LOAD consumes pending in its first cycle. An rx_rdy with pending already
//          set drops the byte and sets overrun.
//  START:  core_start=1 for exactly 1 cycle -> WAIT. First START cycle is the cycle
//          after the final pixel write.
//  WAIT:   core_done -> digit<=core_digit (same edge) -> TX.
//  TX:     when tx_rdy=1: tx_start=1 for 1 cycle, tx_data=8'h30+digit -> IDLE, counters cleared.
//  rx_rdy in START/WAIT/TX is ignored and sets overrun.
//  core_done outside WAIT is ignored; digit is not updated.
//  digit holds its value across frames until the next core_done in WAIT.
//  overrun clears only on reset.
//  Reset mid-frame aborts immediately: partial RAM contents are left as-is, and the
//  next frame restarts at address 0.
//  byte_cnt is 7 bits; bit_cnt is 3 bits and wraps 7->0. No arithmetic overflow is
//  possible for NUM_BYTES<=127.
// CONFIGURATION
//  SNN_CTRL_TIMEOUT_EN defined:
//    - WAIT counts cycles. On reaching TIMEOUT_CYCLES without core_done, go to TX
//      with tx_data=8'h3F ('?'); digit is unchanged.
//    - The counter clears when entering WAIT.
//  Undefined: no counter; WAIT blocks until core_done.
// TESTING
//  1. After reset release: all outputs 0, busy=0, no ram_we/core_start/tx_start
//     for 100 cycles.
//  2. Send 98 bytes of 8'hFF -> 784 writes, addr 0..783 ascending, data=1.
//     Then exactly one core_start, the cycle after addr 783.
//  3. Byte0=8'h01, bytes1..97=8'h00 -> addr0 data 1, addr1..783 data 0.
//  4. In WAIT, core_done with core_digit=7 -> digit=7.
//     With tx_rdy=1: one tx_start, tx_data=8'h37; busy=0 afterwards.
//  5. Two rx_rdy pulses 2 cycles apart -> both bytes written, overrun=0.
//     A third pulse during the same UNPACK -> overrun=1.
//  6. Assert rst_n low after 40 bytes, release, send a full frame -> writes restart at addr 0.
//     With SNN_CTRL_TIMEOUT_EN: withhold core_done -> tx_data=8'h3F after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/snn_ctrl.sv
// Control FSM for the SNN digit classifier: unpacks a UART-received binary image into
// the input RAM, runs snn_core and sends the result digit as ASCII. Option: SNN_CTRL_TIMEOUT_EN.
module snn_ctrl #(
  parameter int NUM_BYTES      = 98,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  input  logic              tx_rdy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [3:0]        digit,
  output logic              busy,
  output logic              overrun
);

  // Handshake: rx_rdy, core_done and tx_start/core_start are single-cycle pulses;
  // tx_rdy is a level, and a byte is sent only in a TX cycle where tx_rdy is high.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UNPACK, S_START, S_WAIT, S_TX
  } state_e;

  localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       pending_q, pending_d;
  logic [6:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] digit_q, digit_d;
  logic       overrun_q, overrun_d;

`ifdef SNN_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timed_out_q, timed_out_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      pending_q   <= 1'b0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      digit_q     <= '0;
      overrun_q   <= 1'b0;
`ifdef SNN_CTRL_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      pending_q   <= pending_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      digit_q     <= digit_d;
      overrun_q   <= overrun_d;
`ifdef SNN_CTRL_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      timed_out_q <= timed_out_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    pending_d   = pending_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    digit_d     = digit_q;
    overrun_d   = overrun_q;
`ifdef SNN_CTRL_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    timed_out_d = timed_out_q;
`endif
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_data    = 1'b0;
    core_start  = 1'b0;
    tx_start    = 1'b0;
    tx_data     = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (rx_rdy) begin
          shift_d    = rx_data;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_UNPACK;
        end
      end
      S_LOAD: begin
        // A held byte is older than any byte arriving now, so it goes first.
        if (pending_q) begin
          shift_d   = hold_q;
          pending_d = 1'b0;
          state_d   = S_UNPACK;
          if (rx_rdy) begin
            hold_d    = rx_data;
            pending_d = 1'b1;
          end
        end else if (rx_rdy) begin
          shift_d = rx_data;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        ram_we    = 1'b1;
        ram_data  = shift_q[0];
        ram_addr  = ADDR_W'({byte_cnt_q, bit_cnt_q});
        shift_d   = {1'b0, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_cnt_d = byte_cnt_q + 7'd1;
          state_d    = (byte_cnt_q == LAST_BYTE) ? S_START : S_LOAD;
        end
        if (rx_rdy) begin
          if (pending_q) begin
            overrun_d = 1'b1;
          end else begin
            hold_d    = rx_data;
            pending_d = 1'b1;
          end
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
`ifdef SNN_CTRL_TIMEOUT_EN
        wait_cnt_d  = '0;
        timed_out_d = 1'b0;
`endif
      end
      S_WAIT: begin
        if (core_done) begin
          digit_d = core_digit;
          state_d = S_TX;
        end
`ifdef SNN_CTRL_TIMEOUT_EN
        else if (wait_cnt_q == TLIM) begin
          timed_out_d = 1'b1;
          state_d     = S_TX;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
`endif
      end
      S_TX: begin
        if (tx_rdy) begin
          tx_start = 1'b1;
`ifdef SNN_CTRL_TIMEOUT_EN
          tx_data  = timed_out_q ? 8'h3F : (8'h30 + {4'h0, digit_q});
`else
          tx_data  = 8'h30 + {4'h0, digit_q};
`endif
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          pending_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bytes arriving while the core owns the frame have nowhere to go.
    if ((state_q == S_START || state_q == S_WAIT || state_q == S_TX) && rx_rdy) begin
      overrun_d = 1'b1;
    end
  end

  assign digit   = digit_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != S_IDLE);

endmodule
